// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared encodings and parameter helpers for the router allocator
package noc_pkg;

  localparam logic ST_FREE     = 1'b0;
  localparam logic ST_RESERVED = 1'b1;

  // True when an index field of width w can address every one of the ports.
  function automatic bit width_ok(input int ports, input int w);
    return (w >= $clog2(ports));
  endfunction

endpackage

// File: rtl/round_robin_arbiter.sv
// rtl/round_robin_arbiter.sv - combinational round-robin pick starting at a pointer
module round_robin_arbiter #(
  parameter int PORTS = 4,
  parameter int W     = 2
) (
  input  logic [PORTS-1:0] req,
  input  logic [W-1:0]     ptr,
  output logic [W-1:0]     winner,
  output logic             anyReq
);

  // Scan from the pointer upwards with wrap-around; the first hit wins.
  always_comb begin
    winner = '0;
    anyReq = 1'b0;
    for (int k = 0; k < PORTS; k++) begin
      if (!anyReq && req[(int'(ptr) + k) % PORTS]) begin
        anyReq = 1'b1;
        winner = W'((int'(ptr) + k) % PORTS);
      end
    end
  end

endmodule

// File: rtl/route_reserve_allocator.sv
// rtl/route_reserve_allocator.sv - per-output round-robin switch allocator with hold-until-relieve
module route_reserve_allocator
  import noc_pkg::*;
#(
  parameter int PORTS         = 4,
  parameter int REQUEST_WIDTH = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [PORTS-1:0]               routeReserveRequestValid,
  input  logic [PORTS*REQUEST_WIDTH-1:0] routeReserveRequest,
  input  logic [PORTS-1:0]               routeRelieve,
  output logic [PORTS-1:0]               routeReserveStatus,
  output logic [PORTS-1:0]               outReserved,
  output logic [PORTS*REQUEST_WIDTH-1:0] outSelect
);

  localparam int W = REQUEST_WIDTH;

  if (!width_ok(PORTS, REQUEST_WIDTH)) begin : g_bad_width
    $error("REQUEST_WIDTH too small for PORTS");
  end

  logic [PORTS-1:0] w_req [PORTS];
  logic [W-1:0]     w_winner [PORTS];
  logic [PORTS-1:0] w_any;
  logic [PORTS-1:0] w_release;
  logic [PORTS-1:0] w_grant;

  logic             r_state [PORTS];
  logic [W-1:0]     r_owner [PORTS];
  logic [W-1:0]     r_ptr [PORTS];
  logic [PORTS-1:0] r_status;

  // Out-of-range indices simply match no output, so such requesters stall.
  always_comb begin
    for (int o = 0; o < PORTS; o++) begin
      for (int i = 0; i < PORTS; i++) begin
        w_req[o][i] = routeReserveRequestValid[i] &&
                      (routeReserveRequest[i*W +: W] == W'(o));
      end
    end
  end

  for (genvar o = 0; o < PORTS; o++) begin : g_out
    round_robin_arbiter #(
      .PORTS (PORTS),
      .W     (W)
    ) u_arb (
      .req    (w_req[o]),
      .ptr    (r_ptr[o]),
      .winner (w_winner[o]),
      .anyReq (w_any[o])
    );
  end

  always_comb begin
    w_release = '0;
    w_grant   = '0;
    for (int o = 0; o < PORTS; o++) begin
      for (int i = 0; i < PORTS; i++) begin
        if (r_owner[o] == W'(i) && routeRelieve[i]) begin
          w_release[o] = 1'b1;
        end
        if (r_state[o] == ST_FREE && w_any[o] && w_winner[o] == W'(i)) begin
          w_grant[i] = 1'b1;
        end
      end
    end
  end

  // A reserved output ignores all requests, so the grant pulse cannot repeat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_status <= '0;
      for (int o = 0; o < PORTS; o++) begin
        r_state[o] <= ST_FREE;
        r_owner[o] <= '0;
        r_ptr[o]   <= '0;
      end
    end else begin
      r_status <= w_grant;
      for (int o = 0; o < PORTS; o++) begin
        if (r_state[o] == ST_FREE) begin
          if (w_any[o]) begin
            r_state[o] <= ST_RESERVED;
            r_owner[o] <= w_winner[o];
            if (int'(w_winner[o]) == PORTS - 1) begin
              r_ptr[o] <= '0;
            end else begin
              r_ptr[o] <= w_winner[o] + 1'b1;
            end
          end
        end else if (w_release[o]) begin
          r_state[o] <= ST_FREE;
        end
      end
    end
  end

  always_comb begin
    routeReserveStatus = r_status;
    for (int o = 0; o < PORTS; o++) begin
      outReserved[o]        = r_state[o];
      outSelect[o*W +: W]   = r_owner[o];
    end
  end

endmodule
